// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder: turns PS/2 byte streams into key / system / error events
// and tracks Shift/Ctrl/Alt held state.
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned PAUSE_TAIL     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_error,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       sys_valid,
  output logic [7:0] sys_code,
  output logic       frame_err,
  output logic       seq_err,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PW = $clog2(PAUSE_TAIL + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  // held bit order: lshift, rshift, lctrl, rctrl, lalt, ralt
  logic          rdy_meta_q, rdy_sync_q, rdy_prev_q;
  logic [7:0]    byte_q;
  logic          berr_q, bvld_q;
  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          key_valid_q, key_valid_d, key_ext_q, key_ext_d, key_rel_q, key_rel_d;
  logic [7:0]    key_code_q, key_code_d, sys_code_q, sys_code_d;
  logic          sys_valid_q, sys_valid_d, frame_err_q, frame_err_d, seq_err_q, seq_err_d;
  logic [5:0]    held_q, held_d;
  logic          emit, emit_ext, emit_rel, is_sys;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
      rdy_prev_q <= 1'b0;
      byte_q     <= '0;
      berr_q     <= 1'b0;
      bvld_q     <= 1'b0;
    end else begin
      rdy_meta_q <= rx_ready;
      rdy_sync_q <= rdy_meta_q;
      rdy_prev_q <= rdy_sync_q;
      bvld_q     <= rdy_sync_q & ~rdy_prev_q;
      if (rdy_sync_q && !rdy_prev_q) begin
        byte_q <= rx_data;
        berr_q <= rx_error;
      end
    end
  end

  always_comb begin
    is_sys = (byte_q == 8'hFA) || (byte_q == 8'hAA) || (byte_q == 8'hEE) ||
             (byte_q == 8'hFE) || (byte_q == 8'hFC) || (byte_q == 8'h00) ||
             (byte_q == 8'hFF);
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = (state_q == S_IDLE) ? '0 : tmo_q + TW'(1);
    pcnt_d      = pcnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    sys_valid_d = 1'b0;
    sys_code_d  = sys_code_q;
    frame_err_d = 1'b0;
    seq_err_d   = 1'b0;
    held_d      = held_q;
    emit        = 1'b0;
    emit_ext    = 1'b0;
    emit_rel    = 1'b0;

    if (bvld_q) begin
      // a captured byte always beats a timeout expiring in the same cycle
      tmo_d = '0;
      if (berr_q) begin
        frame_err_d = 1'b1;
        state_d     = S_IDLE;
        pcnt_d      = '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (byte_q == 8'hE0) state_d = S_EXT;
            else if (byte_q == 8'hF0) state_d = S_BRK;
            else if (byte_q == 8'hE1) begin
              state_d = S_PAUSE;
              pcnt_d  = PW'(PAUSE_TAIL);
            end else if (is_sys) begin
              sys_valid_d = 1'b1;
              sys_code_d  = byte_q;
            end else emit = 1'b1;
          end
          S_EXT: begin
            if (byte_q == 8'hF0) state_d = S_EXT_BRK;
            else if (byte_q != 8'hE0) begin
              state_d = S_IDLE;
              if (is_sys) begin
                sys_valid_d = 1'b1;
                sys_code_d  = byte_q;
              end else begin
                emit     = 1'b1;
                emit_ext = 1'b1;
              end
            end
          end
          S_BRK: begin
            if (byte_q != 8'hF0) begin
              state_d  = S_IDLE;
              emit     = 1'b1;
              emit_rel = 1'b1;
            end
          end
          S_EXT_BRK: begin
            if (byte_q != 8'hF0) begin
              state_d  = S_IDLE;
              emit     = 1'b1;
              emit_ext = 1'b1;
              emit_rel = 1'b1;
            end
          end
          S_PAUSE: begin
            pcnt_d = pcnt_q - PW'(1);
            if (pcnt_q <= PW'(1)) begin
              pcnt_d      = '0;
              state_d     = S_IDLE;
              key_valid_d = 1'b1;
              key_code_d  = 8'hE1;
              key_ext_d   = 1'b0;
              key_rel_d   = 1'b0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = S_IDLE;
      seq_err_d = 1'b1;
      tmo_d     = '0;
    end

    if (emit) begin
      key_valid_d = 1'b1;
      key_code_d  = byte_q;
      key_ext_d   = emit_ext;
      key_rel_d   = emit_rel;
      unique case ({emit_ext, byte_q})
        9'h012:  held_d[0] = ~emit_rel;
        9'h059:  held_d[1] = ~emit_rel;
        9'h014:  held_d[2] = ~emit_rel;
        9'h114:  held_d[3] = ~emit_rel;
        9'h011:  held_d[4] = ~emit_rel;
        9'h111:  held_d[5] = ~emit_rel;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      pcnt_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      sys_valid_q <= 1'b0;
      sys_code_q  <= '0;
      frame_err_q <= 1'b0;
      seq_err_q   <= 1'b0;
      held_q      <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      pcnt_q      <= pcnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
      sys_valid_q <= sys_valid_d;
      sys_code_q  <= sys_code_d;
      frame_err_q <= frame_err_d;
      seq_err_q   <= seq_err_d;
      held_q      <= held_d;
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_rel_q;
  assign sys_valid   = sys_valid_q;
  assign sys_code    = sys_code_q;
  assign frame_err   = frame_err_q;
  assign seq_err     = seq_err_q;
  assign mod_shift   = held_q[0] | held_q[1];
  assign mod_ctrl    = held_q[2] | held_q[3];
  assign mod_alt     = held_q[4] | held_q[5];

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream of the PS/2 byte receiver. Consumes its received byte, ready level and error flag.
- Turns Set-2 scancode byte streams (make, F0 break, E0 extended, E1 pause) into single-cycle key events.
- Reports keyboard system/status bytes separately and tracks Shift/Ctrl/Alt held state.
- Feeds the keyboard front-end logic in the `clk` domain.

Parameters:
- TIMEOUT_CYCLES, 100000, `clk` cycles allowed between bytes of one multi-byte sequence before it is abandoned (2 ms at 50 MHz).
- PAUSE_TAIL, 7, bytes swallowed after E1 before the pause event is emitted.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte from PS/2 receiver; stable while rx_ready high.
- rx_ready  in  1  receiver ready level; each rising edge marks one new byte. Asynchronous to clk.
- rx_error  in  1  receiver error flag; valid together with rx_ready.
- key_valid  out  1  one-cycle pulse: key event on key_code/key_ext/key_release.
- key_code  out  8  scancode of event (0xE1 for pause).
- key_ext  out  1  event came with E0 prefix.
- key_release  out  1  event is a break (F0 seen).
- sys_valid  out  1  one-cycle pulse: system byte on sys_code.
- sys_code  out  8  system byte (FA, AA, EE, FE, FC, 00, FF).
- frame_err  out  1  one-cycle pulse: byte dropped due to rx_error.
- seq_err  out  1  one-cycle pulse: sequence abandoned by timeout.
- mod_shift  out  1  level: left or right Shift held.
- mod_ctrl  out  1  level: left or right Ctrl held.
- mod_alt  out  1  level: left or right Alt held.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, pause counter 0, sync flops 0. A reset mid-sequence discards the partial sequence.
- Input sync: rx_ready passes through 2 flops, then a rising-edge detect. When the edge is detected, rx_data and rx_error are captured (the sampled edge is cycle E).
- Latency: if rx_ready rises before clk edge k, the edge is detected at k+2 and key_valid/sys_valid/frame_err pulse at k+3 for exactly one cycle.
- Data outputs (key_code, key_ext, key_release, sys_code) hold their last values between pulses.
- rx_error on a captured byte: byte dropped, frame_err pulses, state goes to IDLE, pause counter cleared, modifiers unchanged.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, counter = PAUSE_TAIL.
  - System byte -> sys_valid pulse, stay IDLE.
  - Any other byte -> key event with ext=0, rel=0.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - System byte -> sys_valid pulse, then IDLE.
  - Other byte -> key event with ext=1, rel=0, then IDLE.
- BRK:
  - F0 -> stay BRK.
  - Other byte -> key event with ext=0, rel=1, then IDLE.
- EXT_BRK:
  - F0 -> stay.
  - Other byte -> key event with ext=1, rel=1, then IDLE.
- PAUSE:
  - Each byte decrements the counter; its value is ignored.
  - The byte that takes the counter to 0 emits key_code=E1, ext=0, rel=0, then IDLE.
- Timeout:
  - In any state other than IDLE, the counter increments every cycle and clears on each captured byte.
  - On reaching TIMEOUT_CYCLES-1: state goes to IDLE, seq_err pulses, counter clears.
  - If a byte is captured in the same cycle, the byte wins and is processed in the current state; no seq_err.
  - In IDLE the counter is held at 0.
- Modifiers, updated in the same cycle as the key event:
  - Shift = L 12 or R 59, non-extended only; E0 12 / E0 59 (fake shift) are ignored.
  - Ctrl = 14 or E0 14.
  - Alt = 11 or E0 11.
  - Each of the six keys has its own held bit, set on make and cleared on break; each mod_* output is the OR of its pair.
  - Typematic repeat of a make is harmless.
- New bytes arrive at most once per ~1 ms, so no byte queueing is required. Each edge is processed exactly once.

Test Plan:
- Byte 1C (A) -> key_valid once at k+3, key_code=1C, ext=0, rel=0. Then F0,1C -> one pulse only, on the 1C byte, with rel=1.
- E0,75 then E0,F0,75 -> two events, code 75, ext=1; rel=0 then rel=1. No event on the prefix bytes.
- 12 make -> mod_shift=1; 59 make, then 12 break -> mod_shift stays 1; 59 break -> 0. E0 12 leaves mod_shift unchanged. E0 14 -> mod_ctrl=1.
- E1,14,77,E1,F0,14,F0,77 -> exactly one key_valid, code E1, on the 8th byte. AA in IDLE -> sys_valid, sys_code=AA, no key_valid.
- E0 then silence for TIMEOUT_CYCLES (bench TIMEOUT_CYCLES=50) -> seq_err pulse, back to IDLE. Following 1C -> ext=0.
- F0 with rx_error=1 -> frame_err pulse, state IDLE; next 1C -> rel=0. rst asserted after E0 -> all outputs 0; next 75 -> ext=0.
